// File: rtl/mips_pkg.sv
// Shared front-end constants, fetch state encoding and queue entry layout
// used by the instruction-fetch queue.
package mips_pkg;
  localparam int PC_W    = 11;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CODE_W  = 6;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int OP_HI   = INSTR_W - 1;
  localparam int OP_LO   = INSTR_W - CODE_W;

  localparam logic [CODE_W-1:0] HALT_CODE = 6'h3F;
  localparam logic [PC_W-1:0]   RESET_PC  = '0;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [CODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: IM address/data, branch redirect, and the decode-side
// valid/ready handshake with status.
interface if_fetch_queue_if;
  import mips_pkg::*;

  logic [PC_W-1:0]    im_pc;
  logic [INSTR_W-1:0] im_instr;
  logic               redir_valid;
  logic [PC_W-1:0]    redir_pc;
  logic               out_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CNT_W-1:0]   occupancy;
  logic               halted;

  // Environment side: instruction memory, control unit and decode.
  modport master (
    input  im_pc, out_valid, out_instr, out_pc, occupancy, halted,
    output im_instr, redir_valid, redir_pc, out_ready
  );

  modport slave (
    input  im_instr, redir_valid, redir_pc, out_ready,
    output im_pc, out_valid, out_instr, out_pc, occupancy, halted
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it
// in one cycle and takes priority over push.
module fetch_fifo #(
  parameter int DEPTH_P = 4,
  parameter int WIDTH_P = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH_P-1:0]         wdata_i,
  output logic [WIDTH_P-1:0]         rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH_P):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH_P);

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH_P));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & ~flush_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the IM address,
// queues fetched words and presents them to decode under valid/ready.
module if_fetch_queue
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  if_fetch_queue_if.slave bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  fq_entry_t        wr_entry, rd_entry;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop, push;

  assign wr_entry = {pc_q, bus.im_instr};

  assign pop  = bus.out_valid & bus.out_ready;
  // Redirect wins over push: the word at the old PC is on the wrong path.
  assign push = (state_q == FETCH) & ~bus.redir_valid & (~fifo_full | pop);

  fetch_fifo #(
    .DEPTH_P (DEPTH),
    .WIDTH_P ($bits(fq_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redir_valid),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redir_valid) begin
      state_d = FETCH;
      pc_d    = bus.redir_pc;
    end else if (push) begin
      pc_d = pc_q + PC_W'(1);
      if (opcode_of(bus.im_instr) == HALT_CODE) state_d = HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.im_pc     = pc_q;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_instr = rd_entry.instr;
  assign bus.out_pc    = rd_entry.pc;
  assign bus.occupancy = fifo_count;
  assign bus.halted    = (state_q == HALTED);
endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: expected {pc, instr} pairs are
// queued per scenario and compared as decode accepts each head entry.
module tb_if_fetch_queue;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_queue_if ifc ();

  if_fetch_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  logic            halt_en = 1'b0;
  logic [PC_W-1:0] halt_pc = '0;

  fq_entry_t sb[$];

  function automatic logic [INSTR_W-1:0] im_word(input logic [PC_W-1:0] pc, input logic is_halt);
    logic [CODE_W-1:0] op;
    op = is_halt ? HALT_CODE : {1'b0, pc[4:0]};
    return {op, 4'hA, pc, ~pc};
  endfunction

  always_comb ifc.im_instr = im_word(ifc.im_pc, halt_en && (ifc.im_pc == halt_pc));

  task automatic expect_pc(input logic [PC_W-1:0] pc);
    fq_entry_t e;
    e.pc    = pc;
    e.instr = im_word(pc, halt_en && (pc == halt_pc));
    sb.push_back(e);
  endtask

  // One clock: score the head if decode accepts it, then settle after the edge.
  task automatic step();
    fq_entry_t e;
    if (ifc.out_valid && ifc.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got pc=%0d, expected no delivery", ifc.out_pc);
      end else begin
        e = sb.pop_front();
        if (ifc.out_pc !== e.pc || ifc.out_instr !== e.instr) begin
          errors++;
          $display("FAIL pop_data: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                   ifc.out_pc, ifc.out_instr, e.pc, e.instr);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound, input string name);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d entries left, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.redir_valid = 1'b0;
    ifc.redir_pc    = '0;
    ifc.out_ready   = 1'b0;
    halt_en         = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", ifc.out_valid); end
    checks++; if (ifc.occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d expected 0", ifc.occupancy); end
    checks++; if (ifc.im_pc !== 11'd0) begin errors++; $display("FAIL rst_im_pc: got %0d expected 0", ifc.im_pc); end
    checks++; if (ifc.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b expected 0", ifc.halted); end
    checks++; if (ifc.out_instr !== 32'd0 || ifc.out_pc !== 11'd0) begin
      errors++; $display("FAIL rst_out_zero: got instr=%h pc=%0d expected 0/0", ifc.out_instr, ifc.out_pc);
    end
  endtask

  task automatic test_stream();
    int n = 0;
    do_reset();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) expect_pc(11'(i));
    step();
    n++;
    checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 11'd0) begin
      errors++; $display("FAIL stream_first: got valid=%0b pc=%0d expected 1/0", ifc.out_valid, ifc.out_pc);
    end
    while (sb.size() > 0 && n < 30) begin
      step();
      n++;
    end
    checks++; if (n != 11) begin errors++; $display("FAIL stream_rate: got %0d cycles expected 11", n); end
    checks++; if (ifc.occupancy !== 3'd1) begin errors++; $display("FAIL stream_occ: got %0d expected 1", ifc.occupancy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    checks++; if (ifc.occupancy !== 3'd4) begin errors++; $display("FAIL bp_occ: got %0d expected 4", ifc.occupancy); end
    checks++; if (ifc.im_pc !== 11'd4) begin errors++; $display("FAIL bp_im_pc: got %0d expected 4", ifc.im_pc); end
    checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 11'd0) begin
      errors++; $display("FAIL bp_head: got valid=%0b pc=%0d expected 1/0", ifc.out_valid, ifc.out_pc);
    end
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_pc(11'(i));
    drain(12, "bp");
    checks++; if (ifc.occupancy !== 3'd4) begin errors++; $display("FAIL bp_full_flow: got %0d expected 4", ifc.occupancy); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) step();
    checks++; if (ifc.occupancy !== 3'd3) begin errors++; $display("FAIL redir_pre_occ: got %0d expected 3", ifc.occupancy); end
    ifc.out_ready   = 1'b1;
    ifc.redir_valid = 1'b1;
    ifc.redir_pc    = 11'd100;
    expect_pc(11'd0);
    step();
    ifc.redir_valid = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_pop_kept: got %0d pending expected 0", sb.size()); end
    checks++; if (ifc.out_valid !== 1'b0 || ifc.occupancy !== 3'd0) begin
      errors++; $display("FAIL redir_flush: got valid=%0b occ=%0d expected 0/0", ifc.out_valid, ifc.occupancy);
    end
    checks++; if (ifc.im_pc !== 11'd100) begin errors++; $display("FAIL redir_im_pc: got %0d expected 100", ifc.im_pc); end
    for (int i = 100; i < 103; i++) expect_pc(11'(i));
    step();
    checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 11'd100) begin
      errors++; $display("FAIL redir_target: got valid=%0b pc=%0d expected 1/100", ifc.out_valid, ifc.out_pc);
    end
    drain(10, "redir");
  endtask

  task automatic test_back_to_back();
    ifc.out_ready   = 1'b0;
    ifc.redir_valid = 1'b1;
    ifc.redir_pc    = 11'd200;
    step();
    ifc.redir_pc    = 11'd300;
    step();
    ifc.redir_valid = 1'b0;
    checks++; if (ifc.im_pc !== 11'd300 || ifc.occupancy !== 3'd0) begin
      errors++; $display("FAIL b2b_redir: got im_pc=%0d occ=%0d expected 300/0", ifc.im_pc, ifc.occupancy);
    end
    ifc.out_ready = 1'b1;
    expect_pc(11'd300);
    expect_pc(11'd301);
    drain(10, "b2b");
  endtask

  task automatic test_wrap();
    do_reset();
    ifc.out_ready   = 1'b1;
    ifc.redir_valid = 1'b1;
    ifc.redir_pc    = 11'd2046;
    step();
    ifc.redir_valid = 1'b0;
    expect_pc(11'd2046);
    expect_pc(11'd2047);
    expect_pc(11'd0);
    expect_pc(11'd1);
    drain(10, "wrap");
  endtask

  task automatic test_halt();
    do_reset();
    halt_en = 1'b1;
    halt_pc = 11'd5;
    ifc.out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) expect_pc(11'(i));
    drain(15, "halt");
    for (int i = 0; i < 3; i++) step();
    checks++; if (ifc.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %0b expected 1", ifc.halted); end
    checks++; if (ifc.im_pc !== 11'd6) begin errors++; $display("FAIL halt_im_pc: got %0d expected 6", ifc.im_pc); end
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL halt_no_more: got %0b expected 0", ifc.out_valid); end
    ifc.redir_valid = 1'b1;
    ifc.redir_pc    = 11'd10;
    step();
    ifc.redir_valid = 1'b0;
    halt_en = 1'b0;
    checks++; if (ifc.halted !== 1'b0 || ifc.im_pc !== 11'd10) begin
      errors++; $display("FAIL halt_resume: got halted=%0b im_pc=%0d expected 0/10", ifc.halted, ifc.im_pc);
    end
    for (int i = 10; i < 13; i++) expect_pc(11'(i));
    drain(10, "resume");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) step();
    checks++; if (ifc.occupancy !== 3'd2) begin errors++; $display("FAIL midrst_pre: got %0d expected 2", ifc.occupancy); end
    rst = 1'b1;
    #1;
    checks++; if (ifc.out_valid !== 1'b0 || ifc.occupancy !== 3'd0 || ifc.im_pc !== 11'd0) begin
      errors++; $display("FAIL midrst_async: got valid=%0b occ=%0d im_pc=%0d expected 0/0/0",
                         ifc.out_valid, ifc.occupancy, ifc.im_pc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    expect_pc(11'd0);
    expect_pc(11'd1);
    drain(10, "midrst");
  endtask

  initial begin
    ifc.redir_valid = 1'b0;
    ifc.redir_pc    = '0;
    ifc.out_ready   = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
